// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, CAUSE layout.
package irq_ctrl_pkg;

    localparam int MAX_NSRC      = 16;
    localparam int ID_W          = 4;
    localparam int CAUSE_VLD_BIT = 31;

    localparam logic [11:0] ADDR_PEND  = 12'h000;
    localparam logic [11:0] ADDR_MASK  = 12'h004;
    localparam logic [11:0] ADDR_MODE  = 12'h008;
    localparam logic [11:0] ADDR_CLEAR = 12'h00C;
    localparam logic [11:0] ADDR_CAUSE = 12'h010;
    localparam logic [11:0] ADDR_EOI   = 12'h014;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_src.sv
// One interrupt source: optional two-flop synchronizer (IRQ_SYNC_EN), falling-edge
// detector and edge pending flop where a new edge beats a simultaneous clear.
module irq_src (
    input  logic clk,
    input  logic reset,
    input  logic irq_n,
    input  logic edge_mode,
    input  logic clr,
    output logic pend
);

    logic line_n;

`ifdef IRQ_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= irq_n;
            sync_p1 <= sync_p0;
        end
    end
    assign line_n = sync_p1;
`else
    assign line_n = irq_n;
`endif

    // hist_n is the sampled line; it doubles as the level-mode pending state
    logic hist_n;
    logic edge_pend;
    logic fall;

    assign fall = hist_n & ~line_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_n    <= 1'b1;
            edge_pend <= 1'b0;
        end else begin
            hist_n <= line_n;
            if (edge_mode && fall)
                edge_pend <= 1'b1;
            else if (clr)
                edge_pend <= 1'b0;
        end
    end

    assign pend = edge_mode ? edge_pend : ~hist_n;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: mask, fixed lowest-index priority and a
// request/ack/EOI FSM driving active-low Intr. Optional input sync via IRQ_SYNC_EN.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CS_N,
    input  logic            RD_N,
    input  logic            WR_N,
    input  logic [11:0]     Addr,
    input  logic [31:0]     DataIn,
    input  logic [NSRC-1:0] IrqIn_N,
    output logic [31:0]     DataOut,
    output logic            Intr
);

    logic            rd_en;
    logic            wr_en;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] mode_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] clr_vec;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] isr_id_q;
    logic            any_active;
    logic            cause_ack;
    logic            eoi_ok;
    logic            clear_wr;
    logic            unused_data;
    irq_state_e      state_q;
    irq_state_e      state_d;

    assign rd_en       = ~CS_N & ~RD_N;
    assign wr_en       = ~CS_N & ~WR_N;
    assign unused_data = ^DataIn[31:NSRC];

    assign active     = pend & mask_q;
    assign any_active = |active;
    assign clear_wr   = wr_en && (Addr == ADDR_CLEAR);
    assign cause_ack  = rd_en && (Addr == ADDR_CAUSE) && (state_q == REQ) && any_active;
    assign eoi_ok     = wr_en && (Addr == ADDR_EOI) && (state_q == SERVICE);

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NSRC; i++)
            clr_vec[i] = (clear_wr & DataIn[i]) | (eoi_ok & (isr_id_q == ID_W'(i)));
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_src u_src (
            .clk       (clk),
            .reset     (reset),
            .irq_n     (IrqIn_N[g]),
            .edge_mode (mode_q[g]),
            .clr       (clr_vec[g]),
            .pend      (pend[g])
        );
    end

    // Scan downward so the lowest active index is the last assignment
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i])
                win_id = ID_W'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= '0;
            mode_q   <= '0;
            isr_id_q <= '0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_d;
            if (wr_en && (Addr == ADDR_MASK))
                mask_q <= DataIn[NSRC-1:0];
            if (wr_en && (Addr == ADDR_MODE))
                mode_q <= DataIn[NSRC-1:0];
            if (state_q == REQ && cause_ack)
                isr_id_q <= win_id;
        end
    end

    always_comb begin
        state_d = state_q;
        Intr    = 1'b1;
        case (state_q)
            IDLE: begin
                if (any_active)
                    state_d = REQ;
            end
            REQ: begin
                Intr = 1'b0;
                if (!any_active)
                    state_d = IDLE;
                else if (cause_ack)
                    state_d = SERVICE;
            end
            SERVICE: begin
                if (eoi_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        DataOut = '0;
        if (rd_en) begin
            case (Addr)
                ADDR_PEND: DataOut = 32'(pend);
                ADDR_MASK: DataOut = 32'(mask_q);
                ADDR_MODE: DataOut = 32'(mode_q);
                ADDR_CAUSE: begin
                    if (state_q == REQ) begin
                        DataOut[CAUSE_VLD_BIT] = 1'b1;
                        DataOut[ID_W-1:0]      = win_id;
                    end else if (state_q == SERVICE) begin
                        DataOut[ID_W-1:0] = isr_id_q;
                    end
                end
                default: DataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller; adapts request latency when IRQ_SYNC_EN is defined.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        CS_N;
    logic        RD_N;
    logic        WR_N;
    logic [11:0] Addr;
    logic [31:0] DataIn;
    logic [7:0]  IrqIn_N;
    logic [31:0] DataOut;
    logic        Intr;

    int n_assert;
    int n_fail;

    irq_controller #(.NSRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (CS_N),
        .RD_N    (RD_N),
        .WR_N    (WR_N),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .IrqIn_N (IrqIn_N),
        .DataOut (DataOut),
        .Intr    (Intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
        tick();
        CS_N = 1'b1; WR_N = 1'b1; DataIn = '0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        CS_N = 1'b0; RD_N = 1'b0; Addr = a;
        #1;
        d = DataOut;
        tick();
        CS_N = 1'b1; RD_N = 1'b1;
    endtask

    logic [31:0] rd;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
        Addr = '0; DataIn = '0; IrqIn_N = 8'hFF;
        ticks(2);
        check("intr_in_reset", {31'b0, Intr}, 32'd1);
        reset = 1'b1;
        tick();

        // Reset state
        bus_read(12'h004, rd); check("mask_reset", rd, 32'h0);
        bus_read(12'h008, rd); check("mode_reset", rd, 32'h0);
        bus_read(12'h000, rd); check("pend_reset", rd, 32'h0);
        bus_read(12'h010, rd); check("cause_reset", rd, 32'h0);
        check("intr_reset", {31'b0, Intr}, 32'd1);
        bus_read(12'h020, rd); check("unmapped_read", rd, 32'h0);
        bus_write(12'h004, 32'hFFFF_FFFF);
        bus_read(12'h004, rd); check("mask_upper_ignored", rd, 32'h0000_00FF);

        // Level source 0: request latency, acknowledge, EOI
        bus_write(12'h004, 32'h01);
        IrqIn_N = 8'hFE;
        ticks(LAT - 1);
        check("lvl0_intr_before_lat", {31'b0, Intr}, 32'd1);
        tick();
        check("lvl0_intr_at_lat", {31'b0, Intr}, 32'd0);
        bus_read(12'h010, rd); check("lvl0_cause_req", rd, 32'h8000_0000);
        check("lvl0_intr_after_ack", {31'b0, Intr}, 32'd1);
        bus_read(12'h010, rd); check("lvl0_cause_service", rd, 32'h0);
        IrqIn_N = 8'hFF;
        ticks(LAT);
        bus_write(12'h014, 32'h0);
        tick();
        check("lvl0_intr_after_eoi", {31'b0, Intr}, 32'd1);
        bus_read(12'h000, rd); check("lvl0_pend_cleared", rd, 32'h0);

        // Edge sources 1 and 2 together: priority and EOI re-request
        bus_write(12'h004, 32'h06);
        bus_write(12'h008, 32'h06);
        IrqIn_N = 8'hF9;
        tick();
        IrqIn_N = 8'hFF;
        ticks(LAT - 1);
        check("edge12_intr", {31'b0, Intr}, 32'd0);
        bus_read(12'h000, rd); check("edge12_pend", rd, 32'h06);
        bus_read(12'h010, rd); check("edge12_cause1", rd, 32'h8000_0001);
        check("edge12_intr_ack", {31'b0, Intr}, 32'd1);
        bus_write(12'h014, 32'h0);
        check("edge12_intr_after_eoi", {31'b0, Intr}, 32'd1);
        bus_read(12'h000, rd); check("edge12_pend_after_eoi", rd, 32'h04);
        check("edge12_rereq", {31'b0, Intr}, 32'd0);
        bus_read(12'h010, rd); check("edge12_cause2", rd, 32'h8000_0002);
        bus_write(12'h014, 32'h0);
        tick();
        bus_read(12'h000, rd); check("edge12_pend_final", rd, 32'h0);
        check("edge12_intr_final", {31'b0, Intr}, 32'd1);

        // Level source 3 masked off while in REQ
        bus_write(12'h008, 32'h00);
        bus_write(12'h004, 32'h08);
        IrqIn_N = 8'hF7;
        ticks(LAT);
        check("lvl3_intr", {31'b0, Intr}, 32'd0);
        bus_write(12'h004, 32'h00);
        tick();
        check("lvl3_intr_masked", {31'b0, Intr}, 32'd1);
        bus_read(12'h010, rd); check("lvl3_cause_idle", rd, 32'h0);
        IrqIn_N = 8'hFF;
        ticks(LAT);

        // Edge on source 1 coinciding with CLEAR of bit 1: set wins
        bus_write(12'h008, 32'h02);
        IrqIn_N = 8'hFD;
        tick();
        IrqIn_N = 8'hFF;
        ticks(LAT);
        bus_read(12'h000, rd); check("clr_pend_before", rd, 32'h02);
        IrqIn_N = 8'hFD;
        ticks(LAT - 2);
        bus_write(12'h00C, 32'h02);
        bus_read(12'h000, rd); check("clr_set_wins", rd, 32'h02);
        IrqIn_N = 8'hFF;
        ticks(LAT);
        bus_write(12'h00C, 32'h02);
        bus_read(12'h000, rd); check("clr_plain", rd, 32'h0);

        // Reset asserted during SERVICE
        bus_write(12'h008, 32'h00);
        bus_write(12'h004, 32'h01);
        IrqIn_N = 8'hFE;
        ticks(LAT);
        bus_read(12'h010, rd); check("rst_cause_req", rd, 32'h8000_0000);
        IrqIn_N = 8'hFF;
        #2;
        reset = 1'b0;
        #1;
        check("rst_intr_async", {31'b0, Intr}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        bus_read(12'h004, rd); check("rst_mask_cleared", rd, 32'h0);
        bus_read(12'h000, rd); check("rst_pend_cleared", rd, 32'h0);
        bus_read(12'h010, rd); check("rst_cause_idle", rd, 32'h0);
        bus_write(12'h014, 32'h0);
        tick();
        check("rst_eoi_ignored_intr", {31'b0, Intr}, 32'd1);
        bus_read(12'h010, rd); check("rst_eoi_ignored_cause", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
